// File: rtl/add_sub_bist_ctrl_pkg.sv
// Shared definitions for the add/sub BIST controller: FSM states,
// default LFSR seed and the Fibonacci tap mask (taps 16,14,13,11).
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // A zero seed would lock the LFSR, so it is replaced by the default.
    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        return (s == 16'h0000) ? DEFAULT_SEED : s;
    endfunction

    // One Fibonacci step: shift left, XOR of tapped bits enters bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/add_sub_bist_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load of the (sanitised) seed.
module lfsr16
    import add_sub_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [15:0] value
);

    localparam logic [15:0] SEED_FIXED = fix_seed(SEED);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Next value: load has priority over step.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = SEED_FIXED;
        end else if (step) begin
            value_d = lfsr_next(value_q);
        end
    end

    // State register, reset to the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= SEED_FIXED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/add_sub_bist_ctrl.sv
// BIST controller for an external add/sub unit: drives LFSR vectors,
// checks the returned sum/carry, counts mismatches.
// Optional macro ADD_SUB_BIST_FAIL_CAPTURE_EN adds first-failure capture ports.
module add_sub_bist_ctrl
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NUM_VECTORS = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             mode,
    input  logic [WIDTH:0]   s_d,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef ADD_SUB_BIST_FAIL_CAPTURE_EN
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_mode,
    output logic [WIDTH:0]   fail_s_d,
`endif
    output logic [7:0]       err_count,
    output logic [7:0]       vec_count
);

    localparam logic [8:0] NUM_VEC = 9'(NUM_VECTORS);

    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [7:0]       err_q, err_d, vec_q, vec_d;
    logic             pass_q, pass_d;
    logic             lfsr_load, lfsr_step;
    logic [15:0]      lfsr_val;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   expected;
    logic             mismatch;
    logic             unused_lfsr_bits;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_val)
    );

    // Not every LFSR bit feeds an operand for small WIDTH.
    assign unused_lfsr_bits = ^lfsr_val;

    // Reference result of the unit under test for the currently driven vector.
    always_comb begin
        b_eff    = mode_q ? ~b_q : b_q;
        expected = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode_q};
        mismatch = (s_d != expected) || (cout != expected[WIDTH]);
    end

    // Next-state and datapath updates for the run sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        err_d     = err_q;
        vec_d     = vec_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    err_d     = '0;
                    vec_d     = '0;
                    pass_d    = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                a_d       = lfsr_val[WIDTH-1:0];
                b_d       = lfsr_val[2*WIDTH-1:WIDTH];
                mode_d    = lfsr_val[15];
                lfsr_step = 1'b1;
                state_d   = ST_CHECK;
            end
            ST_CHECK: begin
                vec_d = vec_q + 8'd1;
                if (mismatch && (err_q != 8'hFF)) begin
                    err_d = err_q + 8'd1;
                end
                if ({1'b0, vec_d} < NUM_VEC) begin
                    state_d = ST_DRIVE;
                end else begin
                    // pass is resolved on entry to DONE so it is valid alongside done.
                    state_d = ST_DONE;
                    pass_d  = (err_d == 8'd0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign mode      = mode_q;
    assign err_count = err_q;
    assign vec_count = vec_q;
    assign pass      = pass_q;
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);

`ifdef ADD_SUB_BIST_FAIL_CAPTURE_EN
    logic             fv_q, fv_d, fm_q, fm_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic [WIDTH:0]   fs_q, fs_d;

    // Capture the first mismatching vector of a run; cleared on start.
    always_comb begin
        fv_d = fv_q;
        fa_d = fa_q;
        fb_d = fb_q;
        fm_d = fm_q;
        fs_d = fs_q;
        if ((state_q == ST_IDLE) && start) begin
            fv_d = 1'b0;
            fa_d = '0;
            fb_d = '0;
            fm_d = 1'b0;
            fs_d = '0;
        end else if ((state_q == ST_CHECK) && mismatch && !fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
            fm_d = mode_q;
            fs_d = s_d;
        end
    end

    // Failure capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q <= 1'b0;
            fa_q <= '0;
            fb_q <= '0;
            fm_q <= 1'b0;
            fs_q <= '0;
        end else begin
            fv_q <= fv_d;
            fa_q <= fa_d;
            fb_q <= fb_d;
            fm_q <= fm_d;
            fs_q <= fs_d;
        end
    end

    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_mode  = fm_q;
    assign fail_s_d   = fs_q;
`endif

endmodule

// File: doc/add_sub_bist_ctrl.md
ADD_SUB_BIST_CTRL -- requirements
Module: add_sub_bist_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 4, operand width (legal 2..7); NUM_VECTORS, default 8, vectors per run (1..255); SEED, default 16'hACE1, LFSR seed (0 SHALL be replaced by 16'hACE1).
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- start  in  1  begin run, sampled in IDLE only
- a  out  WIDTH  operand A to add/sub unit
- b  out  WIDTH  operand B to add/sub unit
- mode  out  1  0=add, 1=subtract
- s_d  in  WIDTH+1  result from unit
- cout  in  1  carry/borrow-not from unit
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- pass  out  1  last run had zero mismatches
- err_count  out  8  mismatches in last run, saturating
- vec_count  out  8  vectors checked in current/last run

Function
REQ-004 FSM states SHALL be IDLE, DRIVE, CHECK, DONE; IDLE->DRIVE on start; DRIVE->CHECK always; CHECK->DRIVE if vec_count<NUM_VECTORS after increment, else CHECK->DONE; DONE->IDLE always.
REQ-005 On start, lfsr SHALL load SEED, err_count and vec_count SHALL clear, pass SHALL clear.
REQ-006 In DRIVE, a/b/mode SHALL register lfsr[WIDTH-1:0], lfsr[2*WIDTH-1:WIDTH], lfsr[15]; the lfsr SHALL then advance once (Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0).
REQ-007 First vector SHALL use the seed value unshifted.
REQ-008 In CHECK, expected = a + (mode ? ~b : b) + mode computed in WIDTH+1 bits; mismatch if s_d != expected or cout != expected[WIDTH].
REQ-009 On mismatch err_count SHALL increment, saturating at 255; vec_count SHALL increment every CHECK.
REQ-010 Timing: start sampled at edge 0 -> DRIVE cycle 1, CHECK cycle 2, last CHECK cycle 2*NUM_VECTORS, done high cycle 2*NUM_VECTORS+1.
REQ-011 In DONE, pass SHALL be set to (err_count==0) and held until next start.
REQ-012 busy SHALL be high in DRIVE and CHECK only; start while busy SHALL be ignored.
REQ-013 a/b/mode SHALL hold last driven values in IDLE/DONE.

Reset
REQ-014 rst_n low SHALL force IDLE, a=b=0, mode=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, lfsr=SEED, asynchronously, including mid-run.
REQ-015 After reset release the block SHALL wait for start.

Configuration
REQ-016 Macro ADD_SUB_BIST_FAIL_CAPTURE_EN defined: extra outputs fail_valid(1), fail_a(WIDTH), fail_b(WIDTH), fail_mode(1), fail_s_d(WIDTH+1) SHALL latch the first mismatching vector of a run, cleared on start and reset.
REQ-017 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-018 Shared package add_sub_pkg SHALL hold the FSM state enum, default seed constant, and LFSR tap mask.
REQ-019 Sub-module lfsr16 (load, step, value) SHALL be instantiated once; expected-result logic stays inline.

Verification
REQ-020 Ideal model unit, defaults, start pulse -> done at cycle 17, pass=1, err_count=0, vec_count=8.
REQ-021 Seed 16'hACE1 -> first vector a=4'h1, b=4'hE, mode=1; model returns s_d=5'h03, cout=0 -> no mismatch.
REQ-022 Model with cout stuck at 0 -> err_count equals number of vectors with expected carry 1, pass=0.
REQ-023 NUM_VECTORS=255, model s_d always inverted -> err_count=255, no wrap, pass=0.
REQ-024 rst_n low at cycle 5 of a run -> all outputs at reset values within same cycle; second start runs full 8 vectors.
REQ-025 With ADD_SUB_BIST_FAIL_CAPTURE_EN, first-vector fault injected -> fail_valid=1, fail_a=4'h1, fail_b=4'hE, fail_mode=1.
